fifo_rst_seq: RTL

Initiator side of the VDMA FIFO reset handshake. It accepts a reset request, waits for both FIFO ports to go idle, and drives a fixed-width fifo_rst pulse. It then holds the FIFO invalid for a settle window and signals completion. It sits beside each VDMA line FIFO and feeds that FIFO's fifo_rst input and the downstream invalid-window logic.

---
 rtl/fifo_rst_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fifo_rst_seq.sv
// FIFO reset handshake initiator: drain, fixed-width fifo_rst pulse, settle window, done pulse.
// Optional drain timeout is enabled by defining FIFO_RST_TIMEOUT_EN.
module fifo_rst_seq #(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned SETTLE_CYCLES = 256,
   parameter int unsigned DRAIN_TIMEOUT = 1024
) (
   input  logic clock,
   input  logic rst_n,
   input  logic rst_req,
   input  logic wr_idle,
   input  logic rd_idle,
   output logic fifo_rst,
   output logic rst_busy,
   output logic fifo_ready,
   output logic rst_done,
   output logic drain_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      ASSERT,
      SETTLE,
      DONE
   } state_e;

   localparam int unsigned MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int unsigned MAX_ALL = (MAX_A > DRAIN_TIMEOUT) ? MAX_A : DRAIN_TIMEOUT;

   localparam logic [9:0] RST_LAST    = 10'(RST_CYCLES - 1);
   localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
   localparam logic [9:0] CNT_MAX     = 10'(MAX_ALL - 1);
`ifdef FIFO_RST_TIMEOUT_EN
   localparam logic [9:0] DRAIN_LAST  = 10'(DRAIN_TIMEOUT - 1);
`endif

   state_e     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic       fifo_rst_q, fifo_rst_d;
   logic       rst_busy_q, rst_busy_d;
   logic       fifo_ready_q, fifo_ready_d;
   logic       rst_done_q, rst_done_d;
`ifdef FIFO_RST_TIMEOUT_EN
   logic       drain_timeout_q, drain_timeout_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef FIFO_RST_TIMEOUT_EN
      drain_timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rst_req) state_d = DRAIN;
         end
         DRAIN: begin
            if (wr_idle && rd_idle) begin
               state_d = ASSERT;
               cnt_d   = '0;
`ifdef FIFO_RST_TIMEOUT_EN
            end else if (cnt_q == DRAIN_LAST) begin
               state_d         = ASSERT;
               cnt_d           = '0;
               drain_timeout_d = 1'b1;
`endif
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         ASSERT: begin
            // fifo_rst_q is low here only in the first cycle after rst_n release;
            // hold the count so the power-on pulse is still RST_CYCLES wide.
            if (fifo_rst_q) begin
               if (cnt_q == RST_LAST) begin
                  state_d = SETTLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
         end
         SETTLE: begin
            if (rst_req) begin
               state_d = ASSERT;
               cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         DONE: begin
            // a request seen in DONE is the pending request, taken straight to DRAIN
            cnt_d   = '0;
            state_d = rst_req ? DRAIN : IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      fifo_rst_d   = (state_d == ASSERT);
      rst_busy_d   = (state_d != IDLE);
      fifo_ready_d = (state_d == IDLE);
      rst_done_d   = (state_d == DONE);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ASSERT;
         cnt_q        <= '0;
         fifo_rst_q   <= 1'b0;
         rst_busy_q   <= 1'b1;
         fifo_ready_q <= 1'b0;
         rst_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fifo_rst_q   <= fifo_rst_d;
         rst_busy_q   <= rst_busy_d;
         fifo_ready_q <= fifo_ready_d;
         rst_done_q   <= rst_done_d;
      end
   end

`ifdef FIFO_RST_TIMEOUT_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) drain_timeout_q <= 1'b0;
      else        drain_timeout_q <= drain_timeout_d;
   end
   assign drain_timeout = drain_timeout_q;
`else
   assign drain_timeout = 1'b0;
`endif

   assign fifo_rst   = fifo_rst_q;
   assign rst_busy   = rst_busy_q;
   assign fifo_ready = fifo_ready_q;
   assign rst_done   = rst_done_q;

endmodule
